// File: rtl/sigma_16p_arb.sv
// sigma_16p_arb: four-channel round-robin scheduler around one shared
// accumulate-16 datapath. One channel is granted at a time. The block takes
// 16 sign-magnitude samples from that channel and then emits a 12-bit
// two's-complement frame sum tagged with the channel id.
// Optional feature: define SIGMA_ARB_TIMEOUT_EN to abort a frame after 16
// consecutive stall cycles and pulse err. Otherwise err is tied low.
module sigma_16p_arb #(
    parameter int NCH   = 4,
    parameter int NSAMP = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  ack,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic [11:0] data_out,
    output logic [1:0]  out_ch,
    output logic        syn_out,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  ptr_q;
    logic [3:0]  cnt_q;
    logic [11:0] acc_q;
    logic        busy_q;
    logic [11:0] data_out_q;
    logic [1:0]  out_ch_q;
    logic        syn_q;

    logic [7:0]  sample_s;
    logic        take_s;
    logic [11:0] acc_d;
    logic [3:0]  cnt_d;
    logic [1:0]  pick_s;

    // Sign-magnitude to 12-bit two's complement. Negative zero maps to 0.
    function automatic logic [11:0] sm_to_s12(input logic [7:0] s);
        logic [11:0] m;
        m = {5'b00000, s[6:0]};
        if (s[7]) begin
            return 12'd0 - m;
        end else begin
            return m;
        end
    endfunction

    // Return the first requester at or after p, scanning p, p+1, ... mod NCH.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        logic [1:0] idx;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Acknowledge and accumulate the granted lane. No ack outside BUSY.
    always_comb begin
        sample_s = data_in[{grant_q, 3'b000} +: 8];
        take_s   = (state_q == ST_BUSY) && req[grant_q];
        acc_d    = acc_q + sm_to_s12(sample_s);
        cnt_d    = cnt_q + 4'd1;
        pick_s   = rr_pick(req, ptr_q);
        if (take_s) begin
            ack = 4'b0001 << grant_q;
        end else begin
            ack = 4'b0000;
        end
    end

`ifdef SIGMA_ARB_TIMEOUT_EN
    logic [3:0] stall_q;
    logic       err_q;
`endif

    // Scheduler FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'd0;
            ptr_q      <= 2'd0;
            cnt_q      <= 4'd0;
            acc_q      <= 12'd0;
            busy_q     <= 1'b0;
            data_out_q <= 12'd0;
            out_ch_q   <= 2'd0;
            syn_q      <= 1'b0;
`ifdef SIGMA_ARB_TIMEOUT_EN
            stall_q    <= 4'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            syn_q <= 1'b0;
`ifdef SIGMA_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= pick_s;
                        acc_q   <= 12'd0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
`ifdef SIGMA_ARB_TIMEOUT_EN
                        stall_q <= 4'd0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (take_s) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
`ifdef SIGMA_ARB_TIMEOUT_EN
                        stall_q <= 4'd0;
`endif
                        // Last sample of the frame moves to DONE.
                        if (cnt_q == 4'(NSAMP - 1)) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_BUSY;
                        end
`ifdef SIGMA_ARB_TIMEOUT_EN
                    end else if (stall_q == 4'd15) begin
                        // Sixteenth consecutive stall: drop the frame.
                        err_q   <= 1'b1;
                        ptr_q   <= grant_q + 2'd1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        stall_q <= stall_q + 4'd1;
                    end
`else
                    end else begin
                        state_q <= ST_BUSY;
                    end
`endif
                end
                ST_DONE: begin
                    data_out_q <= acc_q;
                    out_ch_q   <= grant_q;
                    syn_q      <= 1'b1;
                    ptr_q      <= grant_q + 2'd1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign data_out = data_out_q;
    assign out_ch   = out_ch_q;
    assign syn_out  = syn_q;
`ifdef SIGMA_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: doc/sigma_16p_arb.md
# sigma_16p_arb

Four-channel round-robin scheduler wrapped around a shared 16-point sigma (accumulate-16) datapath. Each requester streams 8-bit sign-magnitude samples. The block grants one channel at a time, accepts exactly 16 samples from it, and emits a 12-bit two's-complement sum tagged with the channel number. It sits between the sample sources and downstream consumers of the sigma results, replacing per-channel accumulators.

## Interface

Parameters:
- NCH, 4, number of requesters; fixed at 4, with a 2-bit channel id.
- NSAMP, 16, samples per frame; fixed at 16, with a 4-bit counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- res  in  1  reset; synchronous, active-high.
- req  in  4  per-channel sample valid; req[i] high means data_in[8i+7:8i] holds a valid sample.
- data_in  in  32  four 8-bit sign-magnitude samples; bit 7 is the sign, bits 6:0 are the magnitude.
- ack  out  4  one-hot or zero; ack[i] high means the sample on channel i is consumed this cycle.
- grant_id  out  2  channel currently granted; valid while busy is high.
- busy  out  1  high while a frame is in progress (BUSY state).
- data_out  out  12  signed frame sum; held until the next syn_out.
- out_ch  out  2  channel that produced data_out.
- syn_out  out  1  one-cycle pulse; marks data_out and out_ch as new.
- err  out  1  one-cycle timeout-abort pulse; tied 0 unless SIGMA_ARB_TIMEOUT_EN is defined.

## Operation

- States: IDLE, BUSY, DONE.
- **IDLE:**
  - If any req bit is high, select the first requester at or after the rotating pointer ptr, searching in order ptr, ptr+1, … mod 4.
  - Register the selection into grant_id, clear the sum and the sample counter, and go to BUSY.
  - If no req bit is high, stay in IDLE.
- **BUSY:**
  - ack[grant_id] = req[grant_id], combinational. All other ack bits are 0.
  - On each ack, convert the sample to signed form and add it to the 12-bit sum, then increment the counter.
  - On the 16th ack, go to DONE.
  - Requests on other channels are ignored.
- **DONE:**
  - Load data_out with the sum and out_ch with grant_id, and pulse syn_out.
  - Set ptr = grant_id + 1 (mod 4), then go to IDLE.
- **Sign-magnitude conversion:**
  - Positive value is {0, mag}; negative value is −mag.
  - 1000_0000 (negative zero) contributes 0.
- **Arithmetic range:**
  - Range per frame is −2032..+2032, which fits 12-bit signed with no overflow.
  - The accumulator is 12 bits and never saturates.
- **Reset values:** ack=0, grant_id=0, busy=0, data_out=0, out_ch=0, syn_out=0, err=0, ptr=0, state IDLE.
- **Reset during a frame:** asserting res discards the partial sum and counter. Outputs take their reset values on the next edge.
- **Request timing:** a channel that asserts req while another channel is granted waits. Its req must stay high until it is acked; there is no request latching.

## Timing

- If IDLE sees req at edge T:
  - busy and grant_id are valid from T+1.
  - The earliest acks fall at edges T+1..T+16.
  - DONE is reached and syn_out goes high in cycle T+17.
  - The block is back in IDLE at T+18.
- With continuous requests, the frame period is 18 cycles.
- Stalls (req[grant_id] low in BUSY) delay syn_out by exactly the number of stall cycles.
- data_out and out_ch change only in the syn_out cycle.
- No ack is ever issued in IDLE or DONE.

## Configuration

- **SIGMA_ARB_TIMEOUT_EN defined:**
  - A 4-bit stall counter counts consecutive BUSY cycles with req[grant_id] low. It is cleared on every ack.
  - When it reaches 16, the frame aborts:
    - err pulses for one cycle.
    - There is no syn_out, and data_out/out_ch are unchanged.
    - ptr = grant_id + 1.
    - The next state is IDLE.
- **Not defined:**
  - BUSY waits indefinitely for the granted channel.
  - No stall counter is built, and err is constant 0.

## Test plan

- **Single channel:** ch2 holds req=1 with data 0000_0010. Expect 16 acks on ack[2] only, then syn_out one cycle at T+17 with data_out=0x020 and out_ch=2.
- **Negative samples:**
  - ch0 with 16 × 1000_0001 gives data_out=0xFF0 (−16).
  - ch0 with 16 × 1111_1111 gives data_out=0x810 (−2032).
  - ch0 with 16 × 1000_0000 gives data_out=0x000.
- **Round robin:** all four req held high. Expect out_ch sequence 0,1,2,3,0 with syn_out every 18 cycles, and ack never more than one bit set.
- **Stall:** ch1 streaming 0000_0001 drops req for 5 cycles after 8 acks. Expect data_out=0x010 and syn_out delayed by 5 cycles.
- **Reset mid-frame:** res pulses for one cycle after 8 acks. Next cycle all outputs are 0. The next grant goes to ch0 even if ch1 was granted before.
- **Timeout (macro defined):** the granted channel goes silent after 3 acks. Expect err pulse 16 cycles after the last ack, no syn_out, and the next frame granted to the following channel.
